// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response,
// execute redirect and the decode-side valid/ready handshake.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    modport master (
        output imem_req_valid,
        output imem_addr,
        output if_valid,
        output if_inst,
        output if_pc,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        input  if_valid,
        input  if_inst,
        input  if_pc,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        output if_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues imem requests
// under a credit limit, buffers responses and feeds decode in order.
module fetch_unit #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int QW = $clog2(DEPTH);
    localparam int OW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [QW-1:0] head;
    logic [QW-1:0] tail;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   opc    [MAX_OUTST];
    logic [OW-1:0] o_wr;
    logic [OW-1:0] o_rd;

    logic [CW-1:0] live;
    logic [CW:0]   used;
    logic          empty;
    logic          req_hs;
    logic          rsp;
    logic          push;
    logic          pop;

    // Live requests are those whose responses will still be kept;
    // queue slots are reserved for them so an accept never overflows.
    assign live  = inflight - drop;
    assign used  = {1'b0, count} + {1'b0, live};
    assign empty = (count == '0);

    assign bus.imem_req_valid = !rst && !bus.redirect_valid
                             && (live < CW'(MAX_OUTST))
                             && (used < (CW+1)'(DEPTH));
    assign bus.imem_addr = pc;

    assign req_hs = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp    = bus.imem_rsp_valid;
    assign push   = rsp && (drop == '0) && !bus.redirect_valid;

    // Decode must not consume in a redirect cycle.
    assign bus.if_valid = !empty && !bus.redirect_valid;
    assign pop          = bus.if_valid && bus.if_ready;
    assign bus.if_inst  = empty ? 32'h0 : q_inst[head];
    assign bus.if_pc    = empty ? 32'h0 : q_pc[head];

    function automatic logic [OW-1:0] o_next(input logic [OW-1:0] p);
        return (p == OW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // PC, credit counters, drop count and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            head     <= '0;
            tail     <= '0;
            o_wr     <= '0;
            o_rd     <= '0;
        end else begin
            assert (!(push && count == CW'(DEPTH)))
                else $error("fetch queue written while full");
            inflight <= inflight + CW'(req_hs) - CW'(rsp);
            if (rsp)
                o_rd <= o_next(o_rd);
            if (req_hs)
                o_wr <= o_next(o_wr);
            if (bus.redirect_valid) begin
                pc    <= {bus.redirect_pc[31:2], 2'b00};
                drop  <= inflight - CW'(rsp);
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (req_hs)
                    pc <= pc + 32'd4;
                if (rsp && drop != '0)
                    drop <= drop - 1'b1;
                if (push)
                    tail <= tail + 1'b1;
                if (pop)
                    head <= head + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Request PCs in issue order, and queue payload storage.
    always_ff @(posedge clk) begin
        if (req_hs)
            opc[o_wr] <= pc;
        if (push) begin
            q_inst[tail] <= bus.imem_rsp_data;
            q_pc[tail]   <= opc[o_rd];
        end
    end
endmodule
